// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port data-memory arbiter with port 0 priority, a port 1 starvation guard,
// locked bursts, registered read return and screening of illegal byte-enable writes.
module dm_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [9:0]  addr0,
  input  logic [9:0]  addr1,
  input  logic [3:0]  be0,
  input  logic [3:0]  be1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        last0,
  input  logic        last1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        stall0,
  output logic        err,
  output logic [9:0]  m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_din,
  output logic        m_we,
  input  logic [31:0] m_dout
);
  typedef enum logic [1:0] {NONE, P0, P1} own_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  own_t        own_q, own_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d, err_q, err_d;
  logic        sel_v, sel1, we_s, last_s, be_legal;
  always_comb begin
    sel_v    = req0 | req1;
    // With no request sel1 falls to 0, so the memory bus idles on port 0's values.
    sel1     = (own_q == P0 && req0) ? 1'b0 :
               (own_q == P1 && req1) ? 1'b1 :
               (starve_q == SMAX && req1) ? 1'b1 :
               req0 ? 1'b0 : req1;
    gnt0     = sel_v & ~sel1;
    gnt1     = sel_v & sel1;
    stall0   = req0 & ~gnt0;
    m_addr   = sel1 ? addr1 : addr0;
    m_be     = sel1 ? be1 : be0;
    m_din    = sel1 ? wdata1 : wdata0;
    we_s     = sel1 ? we1 : we0;
    last_s   = sel1 ? last1 : last0;
    be_legal = m_be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    m_we     = sel_v & we_s & be_legal;
    err_d    = sel_v & we_s & ~be_legal;
    own_d    = (sel_v & ~last_s) ? (sel1 ? P1 : P0) : NONE;
    starve_d = gnt1 ? 4'd0 : req1 ? (starve_q == SMAX ? SMAX : starve_q + 4'd1) : starve_q;
    rdata_d  = (sel_v & ~we_s) ? m_dout : rdata_q;
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_q     <= NONE;
      starve_q  <= 4'd0;
      rdata_q   <= 32'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      own_q     <= own_d;
      starve_q  <= starve_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err_q     <= err_d;
    end
  end
  assign rdata   = rdata_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err     = err_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural 1024x32 data memory.
module tb_dm_arbiter;
  logic        clk = 1'b0, rst_n;
  logic        req0, req1, we0, we1, last0, last1;
  logic [9:0]  addr0, addr1;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, stall0, err, m_we;
  logic [31:0] rdata, m_din, m_dout;
  logic [9:0]  m_addr;
  logic [3:0]  m_be;
  logic [31:0] mem [1024];
  int          n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .be0(be0), .be1(be1),
    .wdata0(wdata0), .wdata1(wdata1), .last0(last0), .last1(last1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .stall0(stall0), .err(err),
    .m_addr(m_addr), .m_be(m_be), .m_din(m_din), .m_we(m_we), .m_dout(m_dout)
  );

  assign m_dout = mem[m_addr];
  always @(posedge clk)
    if (m_we)
      for (int i = 0; i < 4; i++)
        if (m_be[i]) mem[m_addr][i*8 +: 8] = m_din[i*8 +: 8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic p0(input logic r, input logic w, input logic [9:0] a, input logic [3:0] b,
                    input logic [31:0] d, input logic l);
    req0 = r; we0 = w; addr0 = a; be0 = b; wdata0 = d; last0 = l;
  endtask

  task automatic p1(input logic r, input logic w, input logic [9:0] a, input logic [3:0] b,
                    input logic [31:0] d, input logic l);
    req1 = r; we1 = w; addr1 = a; be1 = b; wdata1 = d; last1 = l;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[1] = 32'h0000_1111;
    mem[2] = 32'hA5A5_0002;
    mem[3] = 32'h3333_3333;
    mem[5] = 32'h1234_5678;
    rst_n = 1'b0;
    p0(0, 0, 0, 4'hF, 0, 1);
    p1(0, 0, 0, 4'hF, 0, 1);
    step; step; #1;
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_starve", dut.starve_q, 0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_stall0", stall0, 0);

    // single port 0 read
    step; rst_n = 1'b1; p0(1, 0, 10'h005, 4'hF, 0, 1); #1;
    chk("rd_gnt0", gnt0, 1);
    chk("rd_gnt1", gnt1, 0);
    chk("rd_stall0", stall0, 0);
    chk("rd_maddr", m_addr, 10'h005);
    step; p0(0, 0, 0, 4'hF, 0, 1); #1;
    chk("rd_rvalid0", rvalid0, 1);
    chk("rd_rdata", rdata, 32'h1234_5678);
    chk("rd_rvalid1", rvalid1, 0);
    chk("rd_stall0_idle", stall0, 0);

    // both ports requesting continuously: 4 grants to port 0, then one to port 1
    for (int c = 1; c <= 10; c++) begin
      step;
      p0(1, 0, 10'h001, 4'hF, 0, 1);
      p1(1, 0, 10'h002, 4'hF, 0, 1);
      #1;
      chk($sformatf("starv_gnt1_c%0d", c), gnt1, (c % 5 == 0));
      chk($sformatf("starv_gnt0_c%0d", c), gnt0, (c % 5 != 0));
      chk($sformatf("starv_cnt_c%0d", c), dut.starve_q, (c - 1) % 5);
      chk($sformatf("starv_rvalid1_c%0d", c), rvalid1, (c > 1 && (c - 1) % 5 == 0));
      chk($sformatf("starv_rdata_c%0d", c), rdata,
          c == 1 ? 32'h1234_5678 : ((c - 1) % 5 == 0 ? 32'hA5A5_0002 : 32'h0000_1111));
    end

    // port 1 write burst, port 0 arrives on beat 2
    step; p0(0, 0, 0, 4'hF, 0, 1); p1(0, 0, 0, 4'hF, 0, 1);
    step; p1(1, 1, 10'h100, 4'hF, 32'hB000_0000, 0); #1;
    chk("b1_gnt1_beat1", gnt1, 1);
    chk("b1_mwe_beat1", m_we, 1);
    chk("b1_maddr_beat1", m_addr, 10'h100);
    step; p1(1, 1, 10'h101, 4'hF, 32'hB000_0001, 0); p0(1, 0, 10'h005, 4'hF, 0, 1); #1;
    chk("b1_gnt1_beat2", gnt1, 1);
    chk("b1_gnt0_beat2", gnt0, 0);
    chk("b1_stall0_beat2", stall0, 1);
    step; p1(1, 1, 10'h102, 4'hF, 32'hB000_0002, 1); #1;
    chk("b1_gnt1_beat3", gnt1, 1);
    chk("b1_stall0_beat3", stall0, 1);
    step; p1(0, 0, 0, 4'hF, 0, 1); #1;
    chk("b1_gnt0_after", gnt0, 1);
    chk("b1_stall0_after", stall0, 0);
    chk("b1_mem100", mem[10'h100], 32'hB000_0000);
    chk("b1_mem101", mem[10'h101], 32'hB000_0001);
    chk("b1_mem102", mem[10'h102], 32'hB000_0002);
    step; p0(0, 0, 0, 4'hF, 0, 1); #1;
    chk("b1_rvalid0", rvalid0, 1);
    chk("b1_rdata", rdata, 32'h1234_5678);

    // illegal byte enables are granted but dropped
    step; p0(1, 1, 10'h010, 4'b0101, 32'hFFFF_FFFF, 1); #1;
    chk("be_gnt0", gnt0, 1);
    chk("be_mwe_illegal", m_we, 0);
    step; p0(1, 1, 10'h010, 4'b0011, 32'hFFFF_FFFF, 1); #1;
    chk("be_err_pulse", err, 1);
    chk("be_mem_unchanged", mem[10'h010], 32'h0);
    chk("be_mwe_legal", m_we, 1);
    step; p0(0, 0, 0, 4'hF, 0, 1); #1;
    chk("be_err_clear", err, 0);
    chk("be_mem_lowhalf", mem[10'h010], 32'h0000_FFFF);
    chk("be_rvalid0_write", rvalid0, 0);

    // port 0 burst dropped mid-way, port 1 takes over with a lock
    step; p0(1, 0, 10'h003, 4'hF, 0, 0); p1(1, 0, 10'h002, 4'hF, 0, 0); #1;
    chk("drop_gnt0_a", gnt0, 1);
    step; p0(0, 0, 0, 4'hF, 0, 1); #1;
    chk("drop_gnt1_b", gnt1, 1);
    chk("drop_rdata_b", rdata, 32'h3333_3333);
    step; p0(1, 0, 10'h003, 4'hF, 0, 1); p1(1, 0, 10'h002, 4'hF, 0, 1); #1;
    chk("drop_lock_p1_gnt1", gnt1, 1);
    chk("drop_lock_p1_stall0", stall0, 1);
    step; p1(0, 0, 0, 4'hF, 0, 1); #1;
    chk("drop_gnt0_d", gnt0, 1);
    // same again but port 1's beat is final, so no lock forms
    step; p0(1, 0, 10'h003, 4'hF, 0, 0); p1(1, 0, 10'h002, 4'hF, 0, 1); #1;
    chk("nolock_gnt0_e", gnt0, 1);
    step; p0(0, 0, 0, 4'hF, 0, 1); #1;
    chk("nolock_gnt1_f", gnt1, 1);
    step; p0(1, 0, 10'h003, 4'hF, 0, 1); #1;
    chk("nolock_gnt0_g", gnt0, 1);
    chk("nolock_gnt1_g", gnt1, 0);

    // reset in the middle of a port 1 burst
    step; p0(0, 0, 0, 4'hF, 0, 1); p1(0, 0, 0, 4'hF, 0, 1);
    step; p1(1, 0, 10'h002, 4'hF, 0, 0); #1;
    chk("rb_gnt1", gnt1, 1);
    step; rst_n = 1'b0; p1(0, 0, 0, 4'hF, 0, 1); #1;
    chk("rb_rvalid1_pre", rvalid1, 1);
    chk("rb_rdata_pre", rdata, 32'hA5A5_0002);
    step; rst_n = 1'b1; p0(1, 0, 10'h005, 4'hF, 0, 1); p1(1, 0, 10'h002, 4'hF, 0, 0); #1;
    chk("rb_rvalid1_post", rvalid1, 0);
    chk("rb_rdata_post", rdata, 0);
    chk("rb_starve_post", dut.starve_q, 0);
    chk("rb_gnt0_idle_arb", gnt0, 1);
    chk("rb_gnt1_idle_arb", gnt1, 0);
    step; p0(0, 0, 0, 4'hF, 0, 1); p1(0, 0, 0, 4'hF, 0, 1); #1;
    chk("rb_rdata_after", rdata, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
